// File: rtl/itch_msg_parser.sv
// rtl/itch_msg_parser.sv - ITCH 5.0 framer/decoder for A/D/E/X; ITCH_TIMESTAMP_EN adds timestampOut
module itch_msg_parser #(
    parameter int ERR_CNT_W     = 16,
    parameter int STALL_TIMEOUT = 64
) (
    input  logic                 clkIn,
    input  logic                 rstBIn,
    input  logic [7:0]           dataIn,
    input  logic                 dataValidIn,
    input  logic                 packetLostIn,
    output logic                 msgValidOut,
    output logic [7:0]           msgTypeOut,
    output logic [15:0]          stockLocateOut,
    output logic [63:0]          orderRefOut,
    output logic                 sideOut,
    output logic [31:0]          sharesOut,
    output logic [31:0]          priceOut,
`ifdef ITCH_TIMESTAMP_EN
    output logic [47:0]          timestampOut,
`endif
    output logic [ERR_CNT_W-1:0] errCntOut
);

    typedef enum logic [2:0] {LEN_HI, LEN_LO, TYPE, BODY, SKIP} state_t;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d, cnt_q, cnt_d, idle_q, idle_d;
    logic [7:0]            type_q, type_d;
    logic [15:0]           loc_q, loc_d;
    logic [63:0]           ref_q, ref_d;
    logic                  side_q, side_d;
    logic [31:0]           shares_q, shares_d, price_q, price_d;
    logic [ERR_CNT_W-1:0]  err_q, err_d;
    logic                  out_valid_q, out_valid_d, out_side_q, out_side_d;
    logic [7:0]            out_type_q, out_type_d;
    logic [15:0]           out_loc_q, out_loc_d;
    logic [63:0]           out_ref_q, out_ref_d;
    logic [31:0]           out_shares_q, out_shares_d, out_price_q, out_price_d;
`ifdef ITCH_TIMESTAMP_EN
    logic [47:0]           ts_q, ts_d, out_ts_q, out_ts_d;
`endif
    logic                  err_evt, emit, last_byte;

    function automatic logic [15:0] exp_len(input logic [7:0] t);
        case (t)
            "A":     return 16'd36;
            "D":     return 16'd19;
            "E":     return 16'd31;
            "X":     return 16'd23;
            default: return 16'd0;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        idle_d   = idle_q;
        type_d   = type_q;
        loc_d    = loc_q;
        ref_d    = ref_q;
        side_d   = side_q;
        shares_d = shares_q;
        price_d  = price_q;
`ifdef ITCH_TIMESTAMP_EN
        ts_d     = ts_q;
`endif
        err_evt   = 1'b0;
        emit      = 1'b0;
        last_byte = (cnt_q == len_q - 16'd1);

        if (packetLostIn) begin
            state_d = LEN_HI;
            idle_d  = 16'd0;
            err_evt = (state_q != LEN_HI);
        end else if (dataValidIn) begin
            idle_d = 16'd0;
            case (state_q)
                LEN_HI: begin
                    len_d[15:8] = dataIn;
                    state_d     = LEN_LO;
                end
                LEN_LO: begin
                    len_d[7:0] = dataIn;
                    state_d    = ({len_q[15:8], dataIn} == 16'd0) ? LEN_HI : TYPE;
                end
                TYPE: begin
                    type_d   = dataIn;
                    cnt_d    = 16'd1;
                    loc_d    = '0;
                    ref_d    = '0;
                    side_d   = 1'b0;
                    shares_d = '0;
                    price_d  = '0;
`ifdef ITCH_TIMESTAMP_EN
                    ts_d     = '0;
`endif
                    if (len_q == 16'd1) begin
                        state_d = LEN_HI;
                    end else if (exp_len(dataIn) == 16'd0) begin
                        state_d = SKIP;
                    end else if (exp_len(dataIn) == len_q) begin
                        state_d = BODY;
                    end else begin
                        err_evt = 1'b1;
                        state_d = SKIP;
                    end
                end
                BODY: begin
                    // Fields are shift-captured; cleared at TYPE so unused ones stay 0.
                    if (cnt_q == 16'd1 || cnt_q == 16'd2) loc_d = {loc_q[7:0], dataIn};
`ifdef ITCH_TIMESTAMP_EN
                    if (cnt_q >= 16'd5 && cnt_q <= 16'd10) ts_d = {ts_q[39:0], dataIn};
`endif
                    if (cnt_q >= 16'd11 && cnt_q <= 16'd18) ref_d = {ref_q[55:0], dataIn};
                    if (type_q == "A") begin
                        if (cnt_q == 16'd19) side_d = (dataIn == "B");
                        if (cnt_q >= 16'd20 && cnt_q <= 16'd23) shares_d = {shares_q[23:0], dataIn};
                        if (cnt_q >= 16'd32 && cnt_q <= 16'd35) price_d = {price_q[23:0], dataIn};
                    end else if (type_q != "D") begin
                        if (cnt_q >= 16'd19 && cnt_q <= 16'd22) shares_d = {shares_q[23:0], dataIn};
                    end
                    if (last_byte) begin
                        state_d = LEN_HI;
                        emit    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                SKIP: begin
                    if (last_byte) state_d = LEN_HI;
                    else           cnt_d   = cnt_q + 16'd1;
                end
                default: state_d = LEN_HI;
            endcase
        end else if (state_q != LEN_HI) begin
            if (idle_q == 16'(STALL_TIMEOUT - 1)) begin
                state_d = LEN_HI;
                idle_d  = 16'd0;
                err_evt = 1'b1;
            end else begin
                idle_d = idle_q + 16'd1;
            end
        end
    end

    always_comb begin
        out_valid_d  = emit;
        out_type_d   = out_type_q;
        out_loc_d    = out_loc_q;
        out_ref_d    = out_ref_q;
        out_side_d   = out_side_q;
        out_shares_d = out_shares_q;
        out_price_d  = out_price_q;
`ifdef ITCH_TIMESTAMP_EN
        out_ts_d     = out_ts_q;
`endif
        if (emit) begin
            out_type_d   = type_q;
            out_loc_d    = loc_d;
            out_ref_d    = ref_d;
            out_side_d   = side_d;
            out_shares_d = shares_d;
            out_price_d  = price_d;
`ifdef ITCH_TIMESTAMP_EN
            out_ts_d     = ts_d;
`endif
        end
        err_d = err_q;
        if (err_evt && err_q != '1) err_d = err_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge clkIn or negedge rstBIn) begin
        if (!rstBIn) begin
            state_q      <= LEN_HI;
            len_q        <= '0;
            cnt_q        <= '0;
            idle_q       <= '0;
            type_q       <= '0;
            loc_q        <= '0;
            ref_q        <= '0;
            side_q       <= 1'b0;
            shares_q     <= '0;
            price_q      <= '0;
            err_q        <= '0;
            out_valid_q  <= 1'b0;
            out_type_q   <= '0;
            out_loc_q    <= '0;
            out_ref_q    <= '0;
            out_side_q   <= 1'b0;
            out_shares_q <= '0;
            out_price_q  <= '0;
`ifdef ITCH_TIMESTAMP_EN
            ts_q         <= '0;
            out_ts_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            idle_q       <= idle_d;
            type_q       <= type_d;
            loc_q        <= loc_d;
            ref_q        <= ref_d;
            side_q       <= side_d;
            shares_q     <= shares_d;
            price_q      <= price_d;
            err_q        <= err_d;
            out_valid_q  <= out_valid_d;
            out_type_q   <= out_type_d;
            out_loc_q    <= out_loc_d;
            out_ref_q    <= out_ref_d;
            out_side_q   <= out_side_d;
            out_shares_q <= out_shares_d;
            out_price_q  <= out_price_d;
`ifdef ITCH_TIMESTAMP_EN
            ts_q         <= ts_d;
            out_ts_q     <= out_ts_d;
`endif
        end
    end

    assign msgValidOut    = out_valid_q;
    assign msgTypeOut     = out_type_q;
    assign stockLocateOut = out_loc_q;
    assign orderRefOut    = out_ref_q;
    assign sideOut        = out_side_q;
    assign sharesOut      = out_shares_q;
    assign priceOut       = out_price_q;
    assign errCntOut      = err_q;
`ifdef ITCH_TIMESTAMP_EN
    assign timestampOut   = out_ts_q;
`endif

endmodule

// File: tb/tb_itch_msg_parser.sv
// tb/tb_itch_msg_parser.sv - randomized bench for itch_msg_parser with a message-level reference model
module tb_itch_msg_parser;
    localparam int ST = 64;

    logic        clkIn = 1'b0;
    logic        rstBIn, dataValidIn, packetLostIn;
    logic [7:0]  dataIn;
    logic        msgValidOut, sideOut;
    logic [7:0]  msgTypeOut;
    logic [15:0] stockLocateOut;
    logic [63:0] orderRefOut;
    logic [31:0] sharesOut, priceOut;
    logic [15:0] errCntOut;
`ifdef ITCH_TIMESTAMP_EN
    logic [47:0] timestampOut;
`endif

    always #2 clkIn = ~clkIn;

    itch_msg_parser #(.ERR_CNT_W(16), .STALL_TIMEOUT(ST)) dut (
        .clkIn(clkIn), .rstBIn(rstBIn), .dataIn(dataIn), .dataValidIn(dataValidIn),
        .packetLostIn(packetLostIn), .msgValidOut(msgValidOut), .msgTypeOut(msgTypeOut),
        .stockLocateOut(stockLocateOut), .orderRefOut(orderRefOut), .sideOut(sideOut),
        .sharesOut(sharesOut), .priceOut(priceOut),
`ifdef ITCH_TIMESTAMP_EN
        .timestampOut(timestampOut),
`endif
        .errCntOut(errCntOut));

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0]  t;
        logic [15:0] loc;
        logic [63:0] rf;
        logic        sd;
        logic [31:0] sh;
        logic [31:0] pr;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  total = 0;
    int  bad = 0;
    int  exp_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] be(input bq_t b, input int off, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[55:0], b[off+i]};
        return v;
    endfunction

    function automatic int ref_len(input logic [7:0] t);
        case (t)
            "A": return 36;
            "D": return 19;
            "E": return 31;
            "X": return 23;
            default: return 0;
        endcase
    endfunction

    // Whole-message reference: what one complete, uninterrupted message should produce.
    task automatic model(input bq_t b);
        ev_t e;
        int  len = b.size();
        int  rl;
        if (len < 2) return;
        rl = ref_len(b[0]);
        if (rl == 0) return;
        if (len != rl) begin
            exp_err++;
            return;
        end
        e.t   = b[0];
        e.loc = 16'(be(b, 1, 2));
        e.rf  = be(b, 11, 8);
        e.sd  = 1'b0;
        e.sh  = '0;
        e.pr  = '0;
        if (b[0] == "A") begin
            e.sd = (b[19] == "B");
            e.sh = 32'(be(b, 20, 4));
            e.pr = 32'(be(b, 32, 4));
        end else if (b[0] != "D") begin
            e.sh = 32'(be(b, 19, 4));
        end
        exp_q.push_back(e);
    endtask

    task automatic mk(input logic [7:0] t, input int len, output bq_t b);
        b = {};
        for (int i = 0; i < len; i++) b.push_back(8'($urandom));
        if (len > 0) b[0] = t;
        if (t == "A" && len > 19) b[19] = ($urandom_range(1, 0) == 1) ? "B" : "S";
    endtask

    task automatic set_be(inout bq_t b, input int off, input int n, input logic [63:0] v);
        for (int i = 0; i < n; i++) b[off+i] = v[8*(n-1-i) +: 8];
    endtask

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        dataValidIn = 1'b0;
        repeat (gap) tick();
        dataValidIn = 1'b1;
        dataIn      = d;
        tick();
        dataValidIn = 1'b0;
    endtask

    task automatic send_msg(input bq_t b, input int gmin, input int gmax);
        logic [15:0] l = 16'(b.size());
        model(b);
        send_byte(l[15:8], $urandom_range(gmax, gmin));
        send_byte(l[7:0], $urandom_range(gmax, gmin));
        foreach (b[i]) send_byte(b[i], $urandom_range(gmax, gmin));
    endtask

    task automatic compare_sb(input string tag);
        ev_t o, e;
        repeat (2) tick();
        check_val({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check_val({tag, "_type"}, 64'(o.t), 64'(e.t));
            check_val({tag, "_loc"}, 64'(o.loc), 64'(e.loc));
            check_val({tag, "_ref"}, o.rf, e.rf);
            check_val({tag, "_side"}, 64'(o.sd), 64'(e.sd));
            check_val({tag, "_shares"}, 64'(o.sh), 64'(e.sh));
            check_val({tag, "_price"}, 64'(o.pr), 64'(e.pr));
        end
        obs_q.delete();
        exp_q.delete();
        check_val({tag, "_err"}, 64'(errCntOut), 64'(exp_err));
    endtask

    always @(negedge clkIn) begin
        if (rstBIn && msgValidOut)
            obs_q.push_back('{msgTypeOut, stockLocateOut, orderRefOut, sideOut, sharesOut, priceOut});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bq_t b, b2;
        logic [7:0] tl[8];
        rstBIn = 1'b0; dataValidIn = 1'b0; packetLostIn = 1'b0; dataIn = '0;
        repeat (3) tick();
        check_val("rst_valid", 64'(msgValidOut), 64'd0);
        check_val("rst_type", 64'(msgTypeOut), 64'd0);
        check_val("rst_ref", orderRefOut, 64'd0);
        check_val("rst_err", 64'(errCntOut), 64'd0);
        rstBIn = 1'b1;
        tick();

        mk("A", 36, b);
        set_be(b, 1, 2, 64'h0102);
        set_be(b, 11, 8, 64'h1122334455667788);
        b[19] = "B";
        set_be(b, 20, 4, 64'd100);
        set_be(b, 32, 4, 64'h0001E240);
        send_msg(b, 0, 0);
        check_val("t1_pulse", 64'(msgValidOut), 64'd1);
        check_val("t1_type", 64'(msgTypeOut), 64'h41);
        check_val("t1_side", 64'(sideOut), 64'd1);
        check_val("t1_shares", 64'(sharesOut), 64'd100);
        check_val("t1_price", 64'(priceOut), 64'd123456);
        check_val("t1_ref", orderRefOut, 64'h1122334455667788);
        tick();
        check_val("t1_pulse_end", 64'(msgValidOut), 64'd0);
        check_val("t1_hold", 64'(priceOut), 64'd123456);
        compare_sb("t1");

        mk("D", 19, b);
        mk("X", 23, b2);
        set_be(b2, 19, 4, 64'd50);
        send_msg(b, 1, 1);
        check_val("t2_d_shares", 64'(sharesOut), 64'd0);
        check_val("t2_d_price", 64'(priceOut), 64'd0);
        send_msg(b2, 1, 1);
        check_val("t2_x_shares", 64'(sharesOut), 64'd50);
        compare_sb("t2");

        mk("R", 39, b);
        mk("E", 31, b2);
        send_msg(b, 0, 2);
        send_msg(b2, 0, 2);
        compare_sb("t3");

        mk("A", 35, b);
        mk("D", 19, b2);
        send_msg(b, 0, 1);
        send_msg(b2, 0, 1);
        compare_sb("t4");

        mk("A", 36, b);
        send_byte(8'h00, 0);
        send_byte(8'd36, 0);
        for (int i = 0; i < 20; i++) send_byte(b[i], 0);
        dataValidIn = 1'b1; dataIn = b[20]; packetLostIn = 1'b1;
        tick();
        dataValidIn = 1'b0; packetLostIn = 1'b0;
        exp_err++;
        mk("E", 31, b2);
        send_msg(b2, 0, 0);
        compare_sb("t5");

        mk("E", 31, b);
        send_byte(8'h00, 0);
        send_byte(8'd31, 0);
        for (int i = 0; i < 10; i++) send_byte(b[i], 0);
        repeat (ST - 1) tick();
        check_val("t6_no_timeout", 64'(errCntOut), 64'(exp_err));
        send_byte(b[10], 0);
        repeat (ST) tick();
        exp_err++;
        check_val("t6_timeout", 64'(errCntOut), 64'(exp_err));
        mk("X", 23, b2);
        send_msg(b2, 0, 1);
        compare_sb("t6");

        mk("A", 36, b);
        send_byte(8'h00, 0);
        send_byte(8'd36, 0);
        for (int i = 0; i < 15; i++) send_byte(b[i], 0);
        rstBIn = 1'b0;
        #1;
        check_val("t6_rst_valid", 64'(msgValidOut), 64'd0);
        check_val("t6_rst_type", 64'(msgTypeOut), 64'd0);
        check_val("t6_rst_shares", 64'(sharesOut), 64'd0);
        check_val("t6_rst_price", 64'(priceOut), 64'd0);
        check_val("t6_rst_err", 64'(errCntOut), 64'd0);
        tick();
        rstBIn = 1'b1;
        exp_err = 0;
        repeat (5) tick();
        compare_sb("t6_post_rst");

        tl = '{"A", "D", "E", "X", "R", "F", "P", "U"};
        for (int n = 0; n < 60; n++) begin
            logic [7:0] t = tl[$urandom_range(7, 0)];
            int rl = ref_len(t);
            int len;
            if ($urandom_range(15, 0) == 0)      len = 0;
            else if (rl == 0)                    len = $urandom_range(40, 2);
            else if ($urandom_range(7, 0) == 0)  len = ($urandom_range(1, 0) == 1) ? rl + 1 : rl - 1;
            else                                 len = rl;
            mk(t, len, b);
            send_msg(b, 0, 3);
        end
        compare_sb("rnd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
